// File: rtl/usb_rxd.sv
// usb_rxd: USB receive deserializer; locks on the sync byte, rebuilds payload bytes and reports per-frame status
module usb_rxd #(
  parameter logic [7:0] SYNC_DATA = 8'h01,
  parameter int HUNT_MAX = 32,
  parameter int LEN_W = 10,
  parameter int GUARD_STRIP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  input  logic din,
  output logic [7:0] dout,
  output logic dout_vld,
  output logic dout_sop,
  output logic frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic frame_err
);
  localparam int CW = $clog2(HUNT_MAX + 1);
  typedef enum logic [2:0] {IDLE, HUNT, DATA, DROP, DONE} state_t;
  state_t state, state_nx;
  logic [6:0] sr;
  logic [7:0] nb, hold;
  logic [CW-1:0] cnt, cnt_inc;
  logic hold_vld, err, sync_hit, hunt_to, byte_done, fall, emit;
  logic [LEN_W-1:0] byte_cnt;
  assign nb = {sr, din};
  assign cnt_inc = cnt + CW'(1);
  assign sync_hit = state == HUNT && fire && cnt_inc >= CW'(8) && nb == SYNC_DATA;
  assign hunt_to = state == HUNT && fire && !sync_hit && cnt_inc >= CW'(HUNT_MAX);
  assign byte_done = state == DATA && fire && cnt[2:0] == 3'd7;
  assign fall = state == DATA && !fire;
  // a held byte goes out once its successor completes, or at frame end when the last byte is payload
  assign emit = hold_vld && (byte_done || (fall && GUARD_STRIP == 0));
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = fire ? HUNT : IDLE;
      HUNT: state_nx = !fire ? DONE : sync_hit ? DATA : hunt_to ? DROP : HUNT;
      DATA, DROP: state_nx = fire ? state : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr <= '0;
      hold <= '0;
      cnt <= '0;
      hold_vld <= 1'b0;
      err <= 1'b0;
      byte_cnt <= '0;
      dout <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      frame_done <= 1'b0;
      frame_len <= '0;
      frame_err <= 1'b0;
    end else begin
      dout_vld <= emit;
      dout_sop <= emit && byte_cnt == '0;
      frame_done <= state == DONE;
      if (emit) begin
        dout <= hold;
        if (byte_cnt != '1) byte_cnt <= byte_cnt + 1'b1;
      end
      if (fire && (state == IDLE || state == HUNT || state == DATA)) sr <= nb[6:0];
      if (state == IDLE) cnt <= CW'(1);
      if (state == HUNT && fire) cnt <= sync_hit ? '0 : cnt_inc;
      if (state == DATA && fire) cnt <= byte_done ? '0 : cnt_inc;
      if (byte_done) begin
        hold <= nb;
        hold_vld <= 1'b1;
      end
      if ((state == HUNT && (!fire || hunt_to)) || (fall && cnt != '0)) err <= 1'b1;
      if (state == DONE) begin
        frame_len <= byte_cnt;
        frame_err <= err;
        byte_cnt <= '0;
        err <= 1'b0;
        hold_vld <= 1'b0;
      end
    end
endmodule

// File: tb/tb_usb_rxd.sv
// tb_usb_rxd: random and directed frames against a frame-level reference model for two receiver configurations
module tb_usb_rxd;
  logic clk = 0, rst = 0, fire = 0, din = 0;
  logic [7:0] a_dout, b_dout;
  logic a_vld, a_sop, a_done, a_err, b_vld, b_sop, b_done, b_err;
  logic [9:0] a_len;
  logic [2:0] b_len;
  int checks = 0, errors = 0, cyc = 0, c0;
  bit fb[$];
  int qa_b[$], qb_b[$], qa_f[$], qb_f[$];
  int la_b[$], lb_b[$], la_f[$], lb_f[$], la_vc[$], la_dc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  usb_rxd u_a (.clk(clk), .rst(rst), .fire(fire), .din(din), .dout(a_dout), .dout_vld(a_vld),
    .dout_sop(a_sop), .frame_done(a_done), .frame_len(a_len), .frame_err(a_err));
  usb_rxd #(.LEN_W(3), .GUARD_STRIP(0)) u_b (.clk(clk), .rst(rst), .fire(fire), .din(din),
    .dout(b_dout), .dout_vld(b_vld), .dout_sop(b_sop), .frame_done(b_done), .frame_len(b_len),
    .frame_err(b_err));

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // expected bytes are {sop, data}; expected frames are {err, len} with err at bit 16
  always @(negedge clk) if (rst) begin
    if (a_vld) begin
      if (qa_b.size() == 0) cmp("a_extra_byte", int'({a_sop, a_dout}), -1);
      else cmp("a_byte", int'({a_sop, a_dout}), qa_b.pop_front());
      la_b.push_back(int'({a_sop, a_dout}));
      la_vc.push_back(cyc);
    end
    if (a_done) begin
      if (qa_f.size() == 0) cmp("a_extra_frame", int'(a_len), -1);
      else cmp("a_frame", (a_err ? 65536 : 0) + int'(a_len), qa_f.pop_front());
      cmp("a_done_vs_vld", int'(a_vld), 0);
      la_f.push_back((a_err ? 65536 : 0) + int'(a_len));
      la_dc.push_back(cyc);
    end
    if (b_vld) begin
      if (qb_b.size() == 0) cmp("b_extra_byte", int'({b_sop, b_dout}), -1);
      else cmp("b_byte", int'({b_sop, b_dout}), qb_b.pop_front());
      lb_b.push_back(int'({b_sop, b_dout}));
    end
    if (b_done) begin
      if (qb_f.size() == 0) cmp("b_extra_frame", int'(b_len), -1);
      else cmp("b_frame", (b_err ? 65536 : 0) + int'(b_len), qb_f.pop_front());
      cmp("b_done_vs_vld", int'(b_vld), 0);
      lb_f.push_back((b_err ? 65536 : 0) + int'(b_len));
    end
  end

  // frame-level reference: find sync in the sampled bits, slice the rest into bytes
  task automatic model();
    int n, k, nb, del;
    bit e;
    logic [7:0] w, v;
    n = fb.size();
    k = 0;
    for (int j = 8; j <= 32 && j <= n && k == 0; j++) begin
      w = 0;
      for (int i = j - 8; i < j; i++) w = {w[6:0], fb[i]};
      if (w == 8'h01) k = j;
    end
    if (k == 0) begin
      qa_f.push_back(65536);
      qb_f.push_back(65536);
      return;
    end
    nb = (n - k) / 8;
    e = (n - k) % 8 != 0;
    for (int m = 0; m < nb; m++) begin
      v = 0;
      for (int i = 0; i < 8; i++) v = {v[6:0], fb[k + 8 * m + i]};
      if (m < nb - 1) qa_b.push_back((m == 0 ? 256 : 0) + int'(v));
      qb_b.push_back((m == 0 ? 256 : 0) + int'(v));
    end
    del = nb > 0 ? nb - 1 : 0;
    qa_f.push_back((e ? 65536 : 0) + (del > 1023 ? 1023 : del));
    qb_f.push_back((e ? 65536 : 0) + (nb > 7 ? 7 : nb));
  endtask

  task automatic tick(input bit f, input bit d);
    fire = f;
    din = d;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int g);
    repeat (g) tick(0, 1'($urandom));
  endtask
  task automatic add_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) fb.push_back(v[i]);
  endtask
  task automatic frame1();
    fb.delete();
    add_byte(8'h01);
    add_byte(8'hA5);
    add_byte(8'h3C);
    add_byte(8'h00);
  endtask
  task automatic play(input int g);
    model();
    foreach (fb[i]) tick(1, fb[i]);
    idle(g);
  endtask
  task automatic clear_logs();
    la_b.delete(); lb_b.delete(); la_f.delete(); lb_f.delete(); la_vc.delete(); la_dc.delete();
  endtask
  task automatic reset_check(input string nm);
    cmp({nm, "_a"}, int'({a_dout, a_vld, a_sop, a_done, a_len, a_err}), 0);
    cmp({nm, "_b"}, int'({b_dout, b_vld, b_sop, b_done, b_len, b_err}), 0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    reset_check("reset");
    tick(0, 0);
    rst = 1;
    idle(2);
    // sync, A5, 3C, guard
    clear_logs();
    frame1();
    c0 = cyc;
    play(4);
    cmp("t1_nbytes", la_b.size(), 2);
    cmp("t1_byte0", la_b[0], 'h1A5);
    cmp("t1_byte1", la_b[1], 'h03C);
    cmp("t1_frame", la_f[0], 2);
    cmp("t1_latency", la_vc[0] - c0, 24);
    cmp("t1_done_cycle", la_dc[0] - c0, 34);
    cmp("t2_nbytes", lb_b.size(), 3);
    cmp("t2_byte2", lb_b[2], 'h000);
    cmp("t2_frame", lb_f[0], 3);
    // no sync: 40 ones
    clear_logs();
    fb.delete();
    repeat (40) fb.push_back(1);
    play(4);
    cmp("t3_nbytes", la_b.size() + lb_b.size(), 0);
    cmp("t3_frame_a", la_f[0], 65536);
    cmp("t3_frame_b", lb_f[0], 65536);
    // partial byte after A5
    clear_logs();
    fb.delete();
    add_byte(8'h01);
    add_byte(8'hA5);
    repeat (5) fb.push_back(1);
    play(4);
    cmp("t4_nbytes_a", la_b.size(), 0);
    cmp("t4_frame_a", la_f[0], 65536);
    cmp("t4_frame_b", lb_f[0], 65537);
    // reset mid-payload, then resend
    clear_logs();
    frame1();
    for (int i = 0; i < 20; i++) tick(1, fb[i]);
    fire = 0;
    rst = 0;
    #1;
    reset_check("midreset");
    tick(0, 0);
    tick(0, 0);
    rst = 1;
    idle(2);
    play(4);
    cmp("t5_nbytes", la_b.size(), 2);
    cmp("t5_byte0", la_b[0], 'h1A5);
    cmp("t5_frame", la_f[0], 2);
    // back-to-back frames with one low cycle
    clear_logs();
    frame1();
    play(1);
    frame1();
    fb.push_front(0);
    play(4);
    cmp("t6_frames", la_f.size(), 2);
    cmp("t6_nbytes", la_b.size(), 4);
    cmp("t6_frame1", la_f[1], 2);
    // length saturation on the narrow counter
    clear_logs();
    fb.delete();
    add_byte(8'h01);
    repeat (10) add_byte(8'($urandom));
    add_byte(8'h00);
    play(4);
    cmp("sat_len_b", lb_f[0], 7);
    cmp("sat_nbytes_b", lb_b.size(), 11);
    cmp("sat_len_a", la_f[0], 10);
    // random frames
    repeat (80) begin
      fb.delete();
      if ($urandom % 8 == 0) repeat (1 + $urandom % 45) fb.push_back($urandom % 4 != 0);
      else begin
        repeat ($urandom % 11) fb.push_back(1'($urandom));
        add_byte(8'h01);
        repeat ($urandom % 7) add_byte(8'($urandom));
        if ($urandom % 2 == 1) add_byte(8'h00);
        repeat ($urandom % 8) fb.push_back(1'($urandom));
      end
      play(2 + $urandom % 3);
    end
    idle(4);
    cmp("a_pending", qa_b.size() + qa_f.size(), 0);
    cmp("b_pending", qb_b.size() + qb_f.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
